// File: rtl/node_pkg.sv
// Shared defaults, FSM state encoding and the round/saturate helper for the node MAC sequencer.
package node_pkg;

    localparam int N_IN_DEF    = 15;
    localparam int DW_DEF      = 8;
    localparam int WW_DEF      = 8;
    localparam int BW_DEF      = 16;
    localparam int ACC_W_DEF   = 23;
    localparam int FRAC_SH_DEF = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        RND  = 2'd2,
        OUT  = 2'd3
    } state_t;

    // Rounds up only when the dropped part is strictly above one half; exact ties truncate.
    function automatic logic signed [63:0] round_sat(input logic signed [63:0] acc,
                                                     input int frac_sh,
                                                     input int dw,
                                                     input logic relu);
        logic signed [63:0] r;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        logic [63:0]        mask;
        logic               rnd;
        r    = acc >>> frac_sh;
        rnd  = 1'b0;
        mask = 64'd0;
        if (frac_sh > 0) begin
            mask = (64'd1 << (frac_sh - 1)) - 64'd1;
            rnd  = (((acc >> (frac_sh - 1)) & 64'd1) != 64'd0) && ((acc & mask) != 64'd0);
        end
        if (rnd)
            r = r + 64'sd1;
        hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo = relu ? 64'sd0 : -(64'sd1 <<< (dw - 1));
        if (r > hi)
            r = hi;
        else if (r < lo)
            r = lo;
        return r;
    endfunction

endpackage

// File: rtl/node_round_sat.sv
// Accumulator-to-output rounding and clamping. Defining NODE_RELU_EN clamps negatives to zero;
// otherwise the result saturates to the full signed output range.
module node_round_sat
    import node_pkg::*;
#(
    parameter int ACC_W   = ACC_W_DEF,
    parameter int DW      = DW_DEF,
    parameter int FRAC_SH = FRAC_SH_DEF
) (
    input  logic signed [ACC_W-1:0] acc,
    output logic signed [DW-1:0]    y
);

`ifdef NODE_RELU_EN
    localparam logic RELU = 1'b1;
`else
    localparam logic RELU = 1'b0;
`endif

    logic signed [63:0] acc_ext;
    logic signed [63:0] r;

    assign acc_ext = {{(64 - ACC_W){acc[ACC_W-1]}}, acc};
    assign r       = round_sat(acc_ext, FRAC_SH, DW, RELU);
    assign y       = DW'(r);

endmodule

// File: rtl/node_mac_seq.sv
// Sequential single-node MAC: bias preload, one product per cycle, round/saturate, then hold result
// until the consumer takes it.
module node_mac_seq
    import node_pkg::*;
#(
    parameter int N_IN    = N_IN_DEF,
    parameter int DW      = DW_DEF,
    parameter int WW      = WW_DEF,
    parameter int BW      = BW_DEF,
    parameter int ACC_W   = ACC_W_DEF,
    parameter int FRAC_SH = FRAC_SH_DEF,
    localparam int AW     = $clog2(N_IN + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_IN*DW-1:0]   a_flat,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 w_we,
    input  logic [AW-1:0]        w_addr,
    input  logic [BW-1:0]        w_data,
    output logic [DW-1:0]        y,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 busy
);

    state_t                    state_q;
    logic [AW-1:0]             k_q;
    logic signed [ACC_W-1:0]   acc_q;
    logic signed [DW-1:0]      a_q [N_IN];
    logic signed [WW-1:0]      w_q [N_IN];
    logic signed [BW-1:0]      bias_q;
    logic [DW-1:0]             y_q;
    logic                      out_valid_q;
    logic                      pend_q;
    logic [AW-1:0]             pend_addr_q;
    logic [BW-1:0]             pend_data_q;

    logic                      wr_en;
    logic [AW-1:0]             wr_addr;
    logic [BW-1:0]             wr_data;
    logic signed [DW+WW-1:0]   prod;
    logic signed [DW-1:0]      y_rs;

    // A write that arrives together with a start is parked and applied when the operation retires,
    // so the starting operation sees the old coefficients.
    assign wr_en   = (state_q == IDLE && w_we && !in_valid) ||
                     (state_q == OUT && out_ready && pend_q);
    assign wr_addr = (state_q == OUT) ? pend_addr_q : w_addr;
    assign wr_data = (state_q == OUT) ? pend_data_q : w_data;

    assign prod = (DW+WW)'(a_q[k_q]) * (DW+WW)'(w_q[k_q]);

    node_round_sat #(
        .ACC_W   (ACC_W),
        .DW      (DW),
        .FRAC_SH (FRAC_SH)
    ) u_round_sat (
        .acc (acc_q),
        .y   (y_rs)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            k_q         <= '0;
            acc_q       <= '0;
            bias_q      <= '0;
            y_q         <= '0;
            out_valid_q <= 1'b0;
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
            pend_data_q <= '0;
            for (int i = 0; i < N_IN; i++) begin
                w_q[i] <= '0;
                a_q[i] <= '0;
            end
        end else begin
            if (wr_en) begin
                if (wr_addr == AW'(N_IN))
                    bias_q <= wr_data;
                else if (wr_addr < AW'(N_IN))
                    w_q[wr_addr] <= wr_data[WW-1:0];
            end
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        for (int i = 0; i < N_IN; i++)
                            a_q[i] <= a_flat[i*DW +: DW];
                        acc_q       <= ACC_W'(bias_q);
                        k_q         <= '0;
                        pend_q      <= w_we;
                        pend_addr_q <= w_addr;
                        pend_data_q <= w_data;
                        state_q     <= MAC;
                    end
                end
                MAC: begin
                    acc_q <= acc_q + ACC_W'(prod);
                    if (k_q == AW'(N_IN - 1))
                        state_q <= RND;
                    else
                        k_q <= k_q + 1'b1;
                end
                RND: begin
                    y_q         <= y_rs;
                    out_valid_q <= 1'b1;
                    state_q     <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        pend_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign y         = y_q;
    assign out_valid = out_valid_q;

endmodule
